bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 118 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle).
// Accepts a BIN_W-bit unsigned operand and produces a packed 8-digit BCD
// result plus an overflow flag for values above 99,999,999.
// Optional build macro BCD_OVERFLOW_SAT_EN: when defined, an overflowing
// result saturates to 32'h9999_9999; otherwise the low 8 digits are kept.
`timescale 1ns/1ps

module bin_to_bcd_seq #(
  parameter int unsigned BIN_W = 27
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic [31:0]      bcd_out,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

  state_e           state_q, state_d;
  logic [35:0]      acc_q, acc_d;
  logic [31:0]      acc_adj;
  logic [BIN_W-1:0] opd_q, opd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [31:0]      bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             load, step, finish;

  // State register and datapath registers, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      opd_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StShift;
      StShift:  if (cnt_d == '0) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output and strobe decode from the current state.
  always_comb begin
    load   = (state_q == StIdle) && start;
    step   = (state_q == StShift);
    finish = (state_q == StFinish);
    busy   = (state_q != StIdle);
  end

  // Add-3 correction on the low eight digits. The operand is below 2^27 < 10^9,
  // so the ninth digit never reaches 5 and needs no correction.
  always_comb begin
    acc_adj = acc_q[31:0];
    for (int i = 0; i < 8; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // Datapath next-state: load on accept, one dabble step per SHIFT cycle,
  // publish the result in FINISH (done/bcd_out become visible on that edge).
  always_comb begin
    acc_d  = acc_q;
    opd_d  = opd_q;
    cnt_d  = cnt_q;
    bcd_d  = bcd_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    if (load) begin
      opd_d = bin_in;
      acc_d = '0;
      cnt_d = CntW'(BIN_W);
    end
    if (step) begin
      acc_d = {acc_q[34:32], acc_adj, opd_q[BIN_W-1]};
      opd_d = {opd_q[BIN_W-2:0], 1'b0};
      cnt_d = cnt_q - CntW'(1);
    end
    if (finish) begin
      ovf_d  = |acc_q[35:32];
      done_d = 1'b1;
`ifdef BCD_OVERFLOW_SAT_EN
      bcd_d  = (|acc_q[35:32]) ? 32'h9999_9999 : acc_q[31:0];
`else
      bcd_d  = acc_q[31:0];
`endif
    end
  end

  assign bcd_out  = bcd_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a cycle model predicts busy/done,
// a scoreboard queue holds expected results pushed at each accepted start.
`timescale 1ns/1ps

module tb_bin_to_bcd_seq;

  localparam int unsigned BW = 27;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [BW-1:0] bin_in;
  logic [31:0]   bcd_out;
  logic          busy, done, overflow;

  bin_to_bcd_seq #(.BIN_W(BW)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .bcd_out  (bcd_out),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int unsigned done_cyc = 0;
  int unsigned busy_left = 0;
  bit          done_seen;
  logic [31:0] last_bcd = '0;
  logic        last_ovf = 1'b0;
  logic [32:0] sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected {overflow, bcd_out} for an operand.
  function automatic logic [32:0] exp_of(input int unsigned v);
    logic [31:0] r;
    int unsigned m;
    logic        o;
    m = v % 100000000;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    o = (v > 99999999);
`ifdef BCD_OVERFLOW_SAT_EN
    if (o) r = 32'h9999_9999;
`endif
    return {o, r};
  endfunction

  // One clock: sample inputs seen by the edge, advance the model, check outputs.
  task automatic tick();
    logic          s, r;
    logic [BW-1:0] b;
    logic [32:0]   e;
    bit            exp_done;
    s = start; r = reset; b = bin_in;
    @(posedge clock);
    #1;
    cyc++;
    exp_done = 0;
    if (r) begin
      if (busy_left > 0 && sb.size() > 0) void'(sb.pop_back());
      busy_left = 0;
      last_bcd  = '0;
      last_ovf  = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) exp_done = 1;
    end else if (s) begin
      busy_left = BW + 1;
      sb.push_back(exp_of(int'(b)));
      acc_cyc = cyc;
    end
    if (exp_done && sb.size() > 0) begin
      e = sb.pop_front();
      last_bcd = e[31:0];
      last_ovf = e[32];
    end
    check("busy", 64'(busy), 64'(busy_left > 0));
    check("done", 64'(done), 64'(exp_done));
    check("bcd_out", 64'(bcd_out), 64'(last_bcd));
    check("overflow", 64'(overflow), 64'(last_ovf));
    if (done === 1'b1) begin
      done_seen = 1;
      check("latency", 64'(cyc - acc_cyc), 64'(BW + 1));
      done_cyc = cyc;
    end
  endtask

  task automatic wait_done();
    done_seen = 0;
    for (int i = 0; i < 40 && !done_seen; i++) tick();
    if (!done_seen) check("done_timeout", 64'(done_seen), 64'd1);
  endtask

  task automatic convert(input int unsigned v);
    start  = 1'b1;
    bin_in = BW'(v);
    tick();
    start  = 1'b0;
    bin_in = BW'($urandom);  // operand in flight must not follow bin_in
    wait_done();
  endtask

  initial begin
    int unsigned d1;
    reset  = 1'b1;
    start  = 1'b1;  // reset must win over start
    bin_in = BW'(5);
    tick();
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("rst_bcd", 64'(bcd_out), 64'h0);
    check("rst_flags", 64'({overflow, busy, done}), 64'h0);

    convert(0);
    check("zero", 64'(bcd_out), 64'h0);
    convert(12345678);
    check("mid", 64'(bcd_out), 64'h1234_5678);
    convert(99999999);
    check("max_ok", 64'({overflow, bcd_out}), {31'h0, 1'b0, 32'h9999_9999});
    convert(134217727);
    check("ovf_flag_full", 64'(overflow), 64'h1);
    convert(100000000);
    check("ovf_flag_1e8", 64'(overflow), 64'h1);
    for (int k = 0; k < 4; k++) convert($urandom_range(0, (1 << BW) - 1));
    convert(9);

    // Start ignored while busy, then back-to-back start in the done cycle.
    start = 1'b1; bin_in = BW'(5);
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    start = 1'b1; bin_in = BW'(7);
    tick();
    start = 1'b0;
    wait_done();
    check("first_res", 64'(bcd_out), 64'h5);
    d1 = done_cyc;
    start = 1'b1; bin_in = BW'(9);
    tick();
    start = 1'b0;
    wait_done();
    check("second_res", 64'(bcd_out), 64'h9);
    check("b2b_gap", 64'(done_cyc - d1), 64'(BW + 2));

    // Reset aborts a conversion in flight.
    convert(42);
    check("res_42", 64'(bcd_out), 64'h42);
    start = 1'b1; bin_in = BW'(77);
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_out", 64'({overflow, busy, done, bcd_out}), 64'h0);
    for (int i = 0; i < 35; i++) tick();
    check("abort_quiet", 64'(bcd_out), 64'h0);
    convert(77);
    check("fresh_77", 64'(bcd_out), 64'h77);
    check("sb_drained", 64'(sb.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
